// File: rtl/hdc_assoc_pkg.sv
// rtl/hdc_assoc_pkg.sv - shared sizes and state encoding for the associative search engine
package hdc_assoc_pkg;

    localparam int FRAME_WIDTH = 64;
    localparam int NUM_FRAMES  = 3;
    localparam int NUM_CLASSES = 8;
    localparam int CLASS_ID_W  = 3;
    localparam int FRAME_IDX_W = 2;
    localparam int DIST_W      = 8;
    localparam int HV_WIDTH    = FRAME_WIDTH * NUM_FRAMES;
    localparam int CNT_W       = $clog2(FRAME_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/hvec_popcount.sv
// rtl/hvec_popcount.sv - combinational popcount of one frame as a binary adder tree
module hvec_popcount
    import hdc_assoc_pkg::*;
(
    input  logic [FRAME_WIDTH-1:0] vec,
    output logic [CNT_W-1:0]       count
);

    // Heap-ordered tree: leaves at [FRAME_WIDTH-1 ..], node i sums children 2i+1 and 2i+2.
    logic [CNT_W-1:0] node [0:2*FRAME_WIDTH-2];

    always_comb begin
        for (int i = 0; i < FRAME_WIDTH; i++) begin
            node[FRAME_WIDTH-1+i] = CNT_W'(vec[i]);
        end
        for (int i = FRAME_WIDTH - 2; i >= 0; i--) begin
            node[i] = node[2*i+1] + node[2*i+2];
        end
        count = node[0];
    end

endmodule

// File: rtl/hvec_assoc_search.sv
// rtl/hvec_assoc_search.sv - scans all class hypervectors and returns the nearest by Hamming distance
module hvec_assoc_search
    import hdc_assoc_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   query_valid,
    output logic                   query_ready,
    input  logic [HV_WIDTH-1:0]    query_vec,
    output logic [CLASS_ID_W-1:0]  frame_id,
    output logic [FRAME_IDX_W-1:0] frame_index,
    input  logic [FRAME_WIDTH-1:0] class_vec_in,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic [CLASS_ID_W-1:0]  result_class,
    output logic [DIST_W-1:0]      result_dist
);

    localparam logic [FRAME_IDX_W-1:0] LAST_IDX = FRAME_IDX_W'(NUM_FRAMES - 1);
    localparam logic [CLASS_ID_W-1:0]  LAST_ID  = CLASS_ID_W'(NUM_CLASSES - 1);

    state_t                  state;
    logic [HV_WIDTH-1:0]     query_q;
    logic [DIST_W-1:0]       acc;
    logic [DIST_W-1:0]       best_dist;
    logic [CLASS_ID_W-1:0]   best_class;
    logic [FRAME_WIDTH-1:0]  query_frame;
    logic [FRAME_WIDTH-1:0]  diff;
    logic [CNT_W-1:0]        pop;
    logic [DIST_W-1:0]       acc_next;
    logic                    new_best;

    assign query_ready = (state == IDLE);
    assign query_frame = query_q[frame_index*FRAME_WIDTH +: FRAME_WIDTH];
    assign diff        = query_frame ^ class_vec_in;
    assign acc_next    = acc + DIST_W'(pop);
    assign new_best    = (acc_next < best_dist);

    hvec_popcount u_popcount (
        .vec   (diff),
        .count (pop)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            query_q      <= '0;
            frame_id     <= '0;
            frame_index  <= '0;
            acc          <= '0;
            best_dist    <= '0;
            best_class   <= '0;
            result_valid <= 1'b0;
            result_class <= '0;
            result_dist  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (query_valid) begin
                        query_q     <= query_vec;
                        frame_id    <= '0;
                        frame_index <= '0;
                        acc         <= '0;
                        best_dist   <= '1;
                        best_class  <= '0;
                        state       <= SCAN;
                    end
                end
                SCAN: begin
                    if (frame_index < LAST_IDX) begin
                        acc         <= acc_next;
                        frame_index <= frame_index + 1'b1;
                    end else begin
                        if (new_best) begin
                            best_dist  <= acc_next;
                            best_class <= frame_id;
                        end
                        acc         <= '0;
                        frame_index <= '0;
                        if (frame_id == LAST_ID) begin
                            // Fold the last class's compare into the result load on this edge.
                            result_class <= new_best ? frame_id : best_class;
                            result_dist  <= new_best ? acc_next : best_dist;
                            result_valid <= 1'b1;
                            state        <= DONE;
                        end else begin
                            frame_id <= frame_id + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        frame_id     <= '0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hvec_assoc_search.sv
// tb/tb_hvec_assoc_search.sv - directed self-checking bench for hvec_assoc_search
module tb_hvec_assoc_search;
    import hdc_assoc_pkg::*;

    logic                   clk;
    logic                   rst_n;
    logic                   query_valid;
    logic                   query_ready;
    logic [HV_WIDTH-1:0]    query_vec;
    logic [CLASS_ID_W-1:0]  frame_id;
    logic [FRAME_IDX_W-1:0] frame_index;
    logic [FRAME_WIDTH-1:0] class_vec_in;
    logic                   result_valid;
    logic                   result_ready;
    logic [CLASS_ID_W-1:0]  result_class;
    logic [DIST_W-1:0]      result_dist;

    int checks = 0;
    int errors = 0;
    int viol   = 0;
    int lat;
    int stub_mode;
    logic [HV_WIDTH-1:0]    stub_q;
    logic [FRAME_WIDTH-1:0] all1;
    logic [FRAME_WIDTH-1:0] sel_frame;
    logic [HV_WIDTH-1:0]    q_ones;
    logic [HV_WIDTH-1:0]    q_pat;

    hvec_assoc_search dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .query_valid  (query_valid),
        .query_ready  (query_ready),
        .query_vec    (query_vec),
        .frame_id     (frame_id),
        .frame_index  (frame_index),
        .class_vec_in (class_vec_in),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result_class (result_class),
        .result_dist  (result_dist)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Class-vector generator stub, combinational on the address.
    always_comb begin
        all1         = '1;
        sel_frame    = stub_q[frame_index*FRAME_WIDTH +: FRAME_WIDTH];
        class_vec_in = '0;
        case (stub_mode)
            0: class_vec_in = all1 >> {frame_id, 3'b000};
            1: class_vec_in = (frame_id == 3'd2 || frame_id == 3'd5) ? sel_frame : ~sel_frame;
            default: class_vec_in = '0;
        endcase
    end

    always @(negedge clk) begin
        if (rst_n && (frame_index == 2'd3 || int'(frame_id) >= NUM_CLASSES)) viol++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic run_query(input logic [HV_WIDTH-1:0] q, output int latency);
        query_vec   = q;
        query_valid = 1'b1;
        @(posedge clk);
        #1;
        query_valid = 1'b0;
        query_vec   = ~q;
        check("busy_after_accept", 32'(query_ready), 0);
        latency = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (result_valid) begin
                latency = n;
                break;
            end
        end
    endtask

    task automatic handshake();
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        result_ready = 1'b0;
        check("valid_drop", 32'(result_valid), 0);
        check("ready_back", 32'(query_ready), 1);
        check("addr_idle", 32'(frame_id), 0);
    endtask

    initial begin
        rst_n        = 1'b0;
        query_valid  = 1'b0;
        query_vec    = '0;
        result_ready = 1'b0;
        stub_mode    = 0;
        stub_q       = '0;
        q_ones       = '1;
        q_pat        = {64'h0123_4567_89AB_CDEF, 64'hDEAD_BEEF_CAFE_F00D, 64'h5A5A_0F0F_3C3C_9696};
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        check("rst_query_ready", 32'(query_ready), 1);
        check("rst_result_valid", 32'(result_valid), 0);
        check("rst_frame_id", 32'(frame_id), 0);
        check("rst_frame_index", 32'(frame_index), 0);
        check("rst_result_class", 32'(result_class), 0);
        check("rst_result_dist", 32'(result_dist), 0);

        // Shifted stub, all-ones query: class 0 is exact.
        stub_mode = 0;
        run_query(q_ones, lat);
        check("t1_latency", 32'(lat), 24);
        check("t1_class", 32'(result_class), 0);
        check("t1_dist", 32'(result_dist), 0);
        handshake();

        // Shifted stub, all-zeros query: distance 3*(64-8k), minimum at k=7.
        run_query('0, lat);
        check("t2_latency", 32'(lat), 24);
        check("t2_class", 32'(result_class), 7);
        check("t2_dist", 32'(result_dist), 24);
        handshake();

        // Classes 2 and 5 equal the query, the rest are its complement.
        stub_mode = 1;
        stub_q    = q_pat;
        run_query(q_pat, lat);
        check("t3_latency", 32'(lat), 24);
        check("t3_class", 32'(result_class), 2);
        check("t3_dist", 32'(result_dist), 0);
        handshake();

        // Every class all zeros against all-ones query: maximum distance.
        stub_mode = 2;
        run_query(q_ones, lat);
        check("t4_class", 32'(result_class), 0);
        check("t4_dist", 32'(result_dist), 192);
        handshake();

        // Result held under back-pressure while a new query is offered.
        stub_mode = 0;
        run_query('0, lat);
        check("t5_latency", 32'(lat), 24);
        query_valid = 1'b1;
        query_vec   = q_ones;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("t5_hold_valid", 32'(result_valid), 1);
            check("t5_hold_class", 32'(result_class), 7);
            check("t5_hold_dist", 32'(result_dist), 24);
            check("t5_hold_qready", 32'(query_ready), 0);
        end
        query_valid = 1'b0;
        handshake();
        @(posedge clk);
        #1;
        check("t5_no_new_accept", 32'(query_ready), 1);

        // Reset in the middle of a scan, at step 11.
        query_vec   = q_ones;
        query_valid = 1'b1;
        @(posedge clk);
        #1;
        query_valid = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        check("t6_pre_frame_id", 32'(frame_id), 3);
        check("t6_pre_frame_index", 32'(frame_index), 2);
        rst_n = 1'b0;
        #1;
        check("t6_rst_frame_id", 32'(frame_id), 0);
        check("t6_rst_frame_index", 32'(frame_index), 0);
        check("t6_rst_valid", 32'(result_valid), 0);
        check("t6_rst_qready", 32'(query_ready), 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("t6_idle_valid", 32'(result_valid), 0);
        run_query('0, lat);
        check("t6_latency", 32'(lat), 24);
        check("t6_class", 32'(result_class), 7);
        check("t6_dist", 32'(result_dist), 24);
        handshake();

        check("addr_range_monitor", 32'(viol), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
